// File: rtl/sf_pkt_fifo_pkg.sv
// Shared types and sizing helpers for the store-and-forward packet FIFO.
package sf_pkt_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PKT     = 2'd1,
    ST_DISCARD = 2'd2
  } wr_state_e;

  localparam int unsigned ENTRY_DATA_W = 32;

  // Storage entry layout; the RTL packs {last, data} in this order at any data width.
  typedef struct packed {
    logic                    last;
    logic [ENTRY_DATA_W-1:0] data;
  } entry_t;

  // One extra pointer bit tells a full ring apart from an empty one.
  function automatic int unsigned ptr_width(input int unsigned depth_lg2);
    return depth_lg2 + 1;
  endfunction

endpackage

// File: rtl/sf_pkt_fifo_mem.sv
// 1W1R flop array with combinational read and optional synchronous clear.
module sf_pkt_fifo_mem #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned WIDTH   = 33,
  parameter int unsigned RST_MEM = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if ((RST_MEM != 0) && !rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sf_pkt_fifo.sv
// Store-and-forward packet FIFO: packets become readable only once committed
// error-free; errored or oversize packets are rolled back and swallowed.
module sf_pkt_fifo
  import sf_pkt_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LG2  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RST_MEM    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  full_o,
  input  logic                  wren_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  wlast_i,
  input  logic                  werror_i,
  output logic                  empty_o,
  input  logic                  rden_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rlast_o,
  output logic                  drop_o,
  output logic [DEPTH_LG2:0]    pkt_cnt_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LG2;
  localparam int unsigned PTR_W = ptr_width(DEPTH_LG2);
  localparam int unsigned ENT_W = DATA_WIDTH + 1;

  wr_state_e        r_state;
  wr_state_e        w_state_nxt;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_cm_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_pkt_cnt;
  logic             r_drop;

  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_cm_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [PTR_W-1:0] w_pkt_cnt_nxt;
  logic [PTR_W-1:0] w_used;
  logic             w_drop_nxt;
  logic             w_fifo_full;
  logic             w_wr_acc;
  logic             w_mem_we;
  logic             w_commit;
  logic             w_oversize;
  logic             w_pop;
  logic             w_pop_last;
  logic [ENT_W-1:0] w_rd_entry;

  assign w_used      = r_wr_ptr - r_rd_ptr;
  assign w_fifo_full = (w_used == PTR_W'(DEPTH));
  assign full_o      = w_fifo_full && (r_state != ST_DISCARD);
  assign empty_o     = (r_rd_ptr == r_cm_ptr);
  assign w_wr_acc    = wren_i && !full_o;
  // A packet filling the whole ring with nothing committed ahead can never complete.
  assign w_oversize  = (r_state == ST_PKT) && w_fifo_full && (r_cm_ptr == r_rd_ptr);
  assign w_pop       = rden_i && !empty_o;
  assign w_pop_last  = w_pop && rlast_o;

  assign {rlast_o, rdata_o} = w_rd_entry;
  assign drop_o             = r_drop;
  assign pkt_cnt_o          = r_pkt_cnt;

  // Write-side FSM: tentative pointer, commit and rollback.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_cm_ptr_nxt = r_cm_ptr;
    w_drop_nxt   = 1'b0;
    w_mem_we     = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE, ST_PKT: begin
        if (w_oversize) begin
          w_wr_ptr_nxt = r_cm_ptr;
          w_drop_nxt   = 1'b1;
          w_state_nxt  = ST_DISCARD;
        end else if (w_wr_acc) begin
          w_mem_we = 1'b1;
          if (werror_i) begin
            w_wr_ptr_nxt = r_cm_ptr;
            w_drop_nxt   = 1'b1;
            w_state_nxt  = wlast_i ? ST_IDLE : ST_DISCARD;
          end else if (wlast_i) begin
            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
            w_cm_ptr_nxt = r_wr_ptr + PTR_W'(1);
            w_commit     = 1'b1;
            w_state_nxt  = ST_IDLE;
          end else begin
            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
            w_state_nxt  = ST_PKT;
          end
        end
      end
      ST_DISCARD: begin
        if (wren_i && wlast_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Read pointer and committed-packet count.
  always_comb begin
    w_rd_ptr_nxt  = r_rd_ptr + PTR_W'(w_pop);
    w_pkt_cnt_nxt = r_pkt_cnt;
    case ({w_commit, w_pop_last})
      2'b10:   w_pkt_cnt_nxt = r_pkt_cnt + PTR_W'(1);
      2'b01:   w_pkt_cnt_nxt = r_pkt_cnt - PTR_W'(1);
      default: w_pkt_cnt_nxt = r_pkt_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_wr_ptr  <= '0;
      r_cm_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_pkt_cnt <= '0;
      r_drop    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_cm_ptr  <= w_cm_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_pkt_cnt <= w_pkt_cnt_nxt;
      r_drop    <= w_drop_nxt;
    end
  end

  sf_pkt_fifo_mem #(
    .ADDR_W  (DEPTH_LG2),
    .WIDTH   (ENT_W),
    .RST_MEM (RST_MEM)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_mem_we),
    .i_waddr (r_wr_ptr[DEPTH_LG2-1:0]),
    .i_wdata ({wlast_i, wdata_i}),
    .i_raddr (r_rd_ptr[DEPTH_LG2-1:0]),
    .o_rdata (w_rd_entry)
  );

endmodule
